// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states, helpers.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mul and div are the only opcodes that go through the iterative engine.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-file read stage,
// the ALU and the writeback FIFO.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   inp1;
  logic [WIDTH-1:0]   inp2;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output in_valid, inp1, inp2, opcode, out_ready,
    input  in_ready, out_valid, result, div_by_zero
  );

  modport slave (
    input  in_valid, inp1, inp2, opcode, out_ready,
    output in_ready, out_valid, result, div_by_zero
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Unsigned iterative engine: one shift-add (mul) or restoring
// shift-subtract (div) step per cycle on WIDTH-bit magnitudes.
// Outputs are the combinational next-step values so the caller can
// register the final answer on the same edge that o_done is high.
module alu_iter_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_mode_div,
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [WIDTH-1:0]   i_mag_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_quot_next;
  logic [WIDTH-1:0]   w_rem_next;

  // Next-step datapath: multiplier consumed LSB first; dividend bits
  // shifted MSB first into the partial remainder.
  always_comb begin
    w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    w_fits      = (w_rem_shift >= {1'b0, r_divisor});
    w_quot_next = {r_quot[WIDTH-2:0], w_fits};
    w_rem_next  = w_fits ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_prod = w_acc_next;
  assign o_quot = w_quot_next;
  assign o_rem  = w_rem_next;

  // Load operands on start, then step until the counter drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_mode_div <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
    end else if (i_start) begin
      r_cnt      <= CNT_W'(WIDTH);
      r_mode_div <= i_mode_div;
      r_acc      <= '0;
      r_mcand    <= {{WIDTH{1'b0}}, i_mag_a};
      r_mplier   <= i_mag_b;
      r_quot     <= i_mag_a;
      r_rem      <= '0;
      r_divisor  <= i_mag_b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_mode_div) begin
        r_quot <= w_quot_next;
        r_rem  <= w_rem_next;
      end else begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential signed ALU with valid/ready on both sides. Single-cycle ops
// and divide-by-zero are resolved on the accept edge; mul/div go through
// the iterative engine and get their sign fix-up on the final step.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  logic               w_accept;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_start;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_done;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [2*WIDTH-1:0] w_single;
  logic               w_single_dbz;
  logic [2*WIDTH-1:0] w_calc_result;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_dbz;
  logic               r_op_div;
  logic               r_sign_diff;
  logic               r_a_neg;
  logic [2*WIDTH-1:0] r_result;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_is_div = (bus.opcode == OP_DIV);
  assign w_b_zero = (bus.inp2 == '0);
  // Divide by zero bypasses the engine and completes like a single-cycle op.
  assign w_start  = w_accept && is_multicycle(bus.opcode) && !(w_is_div && w_b_zero);
  assign w_a_neg  = bus.inp1[WIDTH-1];
  assign w_b_neg  = bus.inp2[WIDTH-1];
  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  assign w_mag_a  = w_a_neg ? -bus.inp1 : bus.inp1;
  assign w_mag_b  = w_b_neg ? -bus.inp2 : bus.inp2;
  assign w_a_ext  = {{WIDTH{w_a_neg}}, bus.inp1};
  assign w_b_ext  = {{WIDTH{w_b_neg}}, bus.inp2};

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_mode_div (w_is_div),
    .i_mag_a    (w_mag_a),
    .i_mag_b    (w_mag_b),
    .o_done     (w_done),
    .o_prod     (w_prod),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // Single-cycle results, including the divide-by-zero answer.
  always_comb begin
    w_single     = '0;
    w_single_dbz = 1'b0;
    case (bus.opcode)
      OP_ADD:  w_single = w_a_ext + w_b_ext;
      OP_SUB:  w_single = w_a_ext - w_b_ext;
      OP_DIV: begin
        w_single     = {{WIDTH{1'b1}}, bus.inp1};
        w_single_dbz = 1'b1;
      end
      OP_OR:   w_single = {{WIDTH{1'b0}}, bus.inp1 | bus.inp2};
      OP_AND:  w_single = {{WIDTH{1'b0}}, bus.inp1 & bus.inp2};
      OP_NOTA: w_single = {{WIDTH{1'b0}}, ~bus.inp1};
      OP_NOTB: w_single = {{WIDTH{1'b0}}, ~bus.inp2};
      default: w_single = '0;
    endcase
  end

  // Sign fix-up: product/quotient negative when signs differ,
  // remainder takes the dividend's sign.
  always_comb begin
    w_prod_fix    = r_sign_diff ? -w_prod : w_prod;
    w_quot_fix    = r_sign_diff ? -w_quot : w_quot;
    w_rem_fix     = r_a_neg ? -w_rem : w_rem;
    w_calc_result = r_op_div ? {w_quot_fix, w_rem_fix} : w_prod_fix;
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_dbz       <= 1'b0;
      r_op_div    <= 1'b0;
      r_sign_diff <= 1'b0;
      r_a_neg     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_start) begin
              r_state     <= CALC;
              r_op_div    <= w_is_div;
              r_sign_diff <= w_a_neg ^ w_b_neg;
              r_a_neg     <= w_a_neg;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_single;
              r_dbz       <= w_single_dbz;
            end
          end
        end
        CALC: begin
          if (w_done) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_calc_result;
            r_dbz       <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the team's 16-bit combinational ALU.
- Same 3-bit opcode map: add, sub, mul, div, or, and, not-a, not-b.
- Operands are WIDTH-bit two's-complement; the result is 2*WIDTH bits.
- Mul/div run iteratively, one bit per cycle. Valid/ready handshakes on both sides let the block sit between a register-file read stage and a writeback FIFO.

Parameters:
- WIDTH, 16, operand width in bits, ≥4. Result width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived from WIDTH; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept an operation
- inp1  in  WIDTH  operand A, signed
- inp2  in  WIDTH  operand B, signed
- opcode  in  3  operation select
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  2*WIDTH  registered result
- div_by_zero  out  1  qualifies result when out_valid and opcode was div

Behaviour:
- Reset (async assert, sync deassert at the block boundary): state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, counter=0.
- Accept: the operation is accepted on a clk edge where in_valid && in_ready.
  - inp1, inp2 and opcode are captured on that edge.
  - Inputs are ignored at all other times.
- in_ready is 1 only in IDLE.
- FSM states are IDLE, CALC and DONE.
  - IDLE -> DONE on accept of a single-cycle op (000, 001, 100-111) or of a divide by zero. Result is registered on the accept edge; out_valid rises the next cycle (latency 1).
  - IDLE -> CALC on accept of mul (010) or div (011) with inp2≠0. The counter loads WIDTH.
  - CALC performs one shift-add (mul) or restoring shift-subtract (div) step per cycle. At counter==1 it applies the sign fix-up, writes result, and goes to DONE. out_valid asserts exactly WIDTH cycles after the accept edge.
  - DONE holds result and div_by_zero stable while out_ready=0. On out_valid && out_ready it goes to IDLE and clears out_valid. No new accept happens in that same cycle.
- Arithmetic, with operands sign-extended to 2*WIDTH:
  - 000: result = A+B, exact, never overflows.
  - 001: result = A-B, exact.
  - 010: operands are converted to WIDTH-bit unsigned magnitudes. |−2^(WIDTH−1)| fits unsigned. The 2*WIDTH-bit product is negated if the operand signs differ. Result is the exact signed product.
  - 011: truncating signed division. result[2W-1:W] = quotient, result[W-1:0] = remainder. Remainder sign follows the dividend, and |rem|<|B|.
  - Div overflow: −2^(WIDTH−1)/−1 gives quotient −2^(WIDTH−1) (wraps) and remainder 0. It is not flagged.
  - Divide by zero: quotient = all ones, remainder = A, div_by_zero=1, latency 1.
  - div_by_zero=0 for every other op and result.
  - 100 OR, 101 AND, 110 ~A, 111 ~B: operate on result[W-1:0]; result[2W-1:W]=0. No X is ever driven.
- Reset mid-CALC or in DONE aborts the operation. The pending result is lost and outputs return to their reset values.
- in_valid/opcode changes while not in_ready have no effect.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=3'b000 … OP_NOTB=3'b111;
  - the state enum IDLE/CALC/DONE;
  - an is_multicycle(opcode) function.
- One sub-module, alu_iter_muldiv, is natural. It takes the magnitude datapath, start, and a mode bit (mul/div). It returns a product, or a quotient and remainder, plus done.
- The top level owns the handshake FSM, the single-cycle ops, the sign handling and the div-by-zero bypass.

Test Plan (WIDTH=16):
- Add carry/sign: opcode=000, A=16'h7FFF, B=16'h0001 -> result 32'h0000_8000, out_valid one cycle after accept. A=16'h8000, B=16'hFFFF -> 32'hFFFF_7FFF.
- Signed multiply: A=−7 (16'hFFF9), B=3 -> after 16 cycles result 32'hFFFF_FFEB. A=B=16'h8000 -> 32'h4000_0000.
- Signed divide: A=−7, B=2 -> 32'hFFFD_FFFF (q=−3, r=−1), div_by_zero=0. A=16'h8000, B=16'hFFFF -> 32'h8000_0000.
- Divide by zero: A=16'h1234, B=0 -> result 32'hFFFF_1234, div_by_zero=1, latency 1, no CALC cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result must be stable, in_ready=0, and a new in_valid must be ignored. Raise out_ready -> one handshake, then in_ready=1 next cycle.
- Reset mid-operation: deassert rst_n asynchronously at CALC cycle 8 of a multiply -> outputs go to 0 immediately, in_ready=1 after release, and the next add completes correctly.
